// File: rtl/lc3_pkg.sv
// Shared constants, state encoding and helpers for the LC-3 operate-instruction issue block.
package lc3_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_N  = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0101;
    localparam logic [OP_W-1:0] OP_NOT = 4'b1001;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic is_operate(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    // One-hot {n,z,p} for a writeback value.
    function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] r);
        if (r[DATA_W-1])
            return NZP_N;
        else if (r == '0)
            return NZP_Z;
        else
            return NZP_P;
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// General-purpose register file: two operand reads, a debug read, and two
// write ports where writeback takes priority over the external loader.
module lc3_regfile
    import lc3_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1_addr,
    output logic [WIDTH-1:0] ra1_data,
    input  logic [AW-1:0]    ra2_addr,
    output logic [WIDTH-1:0] ra2_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ext_en,
    input  logic [AW-1:0]    ext_addr,
    input  logic [WIDTH-1:0] ext_data
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++)
                regs[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (wb_en && (wb_addr == AW'(i)))
                    regs[i] <= wb_data;
                else if (ext_en && (ext_addr == AW'(i)))
                    regs[i] <= ext_data;
            end
        end
    end

    assign ra1_data = regs[ra1_addr];
    assign ra2_data = regs[ra2_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/lc3_operate_issue.sv
// Issue/writeback sequencer for LC-3 ADD/AND/NOT: decode, operand read,
// ALU drive, result capture and register/condition-code writeback.
module lc3_operate_issue
    import lc3_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [15:0]      inst,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [2:0]       nzp,
    output logic             done,
    output logic             illegal
);

    state_t state, state_next;

    logic [15:0]      inst_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] rd_a, rd_b, b_sel;
    logic             accept;
    logic             load_inst, load_alu, load_res, wb_en, done_d, illegal_d;

    logic [3:0] op;
    logic [2:0] dr, sr1, sr2;

    assign accept = inst_valid && inst_ready;
    assign op     = inst_q[15:12];
    assign dr     = inst_q[11:9];
    assign sr1    = inst_q[8:6];
    assign sr2    = inst_q[2:0];

    lc3_regfile #(
        .NREGS (NREGS),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra1_addr (sr1),
        .ra1_data (rd_a),
        .ra2_addr (sr2),
        .ra2_data (rd_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_en    (wb_en),
        .wb_addr  (dr),
        .wb_data  (res_q),
        .ext_en   (wr_en),
        .ext_addr (wr_addr),
        .ext_data (wr_data)
    );

    // Operand b: zero for NOT, sign-extended imm5 or R[SR2] otherwise.
    always_comb begin
        b_sel = rd_b;
        if (op == OP_NOT)
            b_sel = '0;
        else if (inst_q[5])
            b_sel = {{(WIDTH-5){inst_q[4]}}, inst_q[4:0]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Unsupported opcodes are consumed in IDLE without leaving it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_operate(inst[15:12])) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_inst = 1'b0;
        load_alu  = 1'b0;
        load_res  = 1'b0;
        wb_en     = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state)
            IDLE: begin
                load_inst = accept;
                illegal_d = accept && !is_operate(inst[15:12]);
            end
            READ:    load_alu = 1'b1;
            EXEC: begin
                load_res = 1'b1;
                done_d   = 1'b1;
            end
            WB:      wb_en = 1'b1;
            default: ;
        endcase
    end

    // done is launched at the EXEC edge so it is high for the whole WB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_ready <= 1'b1;
            inst_q     <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_q      <= '0;
            nzp        <= NZP_Z;
            done       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            inst_ready <= (state_next == IDLE);
            done       <= done_d;
            illegal    <= illegal_d;
            if (load_inst)
                inst_q <= inst;
            if (load_alu) begin
                alu_opcode <= op;
                alu_a      <= rd_a;
                alu_b      <= b_sel;
            end
            if (load_res)
                res_q <= alu_result;
            if (wb_en)
                nzp <= nzp_of(res_q);
        end
    end

endmodule

// File: tb/tb_lc3_operate_issue.sv
// Directed self-checking bench for lc3_operate_issue with a behavioural ALU.
module tb_lc3_operate_issue;
    import lc3_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [2:0]  nzp;
    logic        done;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_operate_issue dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .nzp        (nzp),
        .done       (done),
        .illegal    (illegal)
    );

    always_comb begin
        case (alu_opcode)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_NOT:  alu_result = ~alu_a;
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    // Offer one instruction for a single edge; returns in cycle 1 (READ).
    task automatic issue(input logic [15:0] i);
        check("ready_before_issue", 32'(inst_ready), 32'd1);
        inst_valid = 1'b1; inst = i;
        tick();
        inst_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
        tick(); tick();
        rst = 1'b0;

        check("rst_ready", 32'(inst_ready), 32'd1);
        check("rst_nzp", 32'(nzp), 32'h2);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_alu", {12'(alu_opcode), alu_a[3:0], alu_b}, 32'd0);
        for (int r = 0; r < 8; r++) check_reg("rst_reg", 3'(r), 16'h0000);

        // ADD R3,R1,R2 with R1=5, R2=3
        wr(3'd1, 16'd5); wr(3'd2, 16'd3);
        issue(16'h1642);
        check("add_c1_ready", 32'(inst_ready), 32'd0);
        check("add_c1_done", 32'(done), 32'd0);
        tick();
        check("add_exec_op", 32'(alu_opcode), 32'h1);
        check("add_exec_a", 32'(alu_a), 32'd5);
        check("add_exec_b", 32'(alu_b), 32'd3);
        check("add_exec_done", 32'(done), 32'd0);
        tick();
        check("add_wb_done", 32'(done), 32'd1);
        check("add_wb_ready", 32'(inst_ready), 32'd0);
        tick();
        check("add_after_done", 32'(done), 32'd0);
        check("add_after_ready", 32'(inst_ready), 32'd1);
        check_reg("add_r3", 3'd3, 16'd8);
        check("add_nzp", 32'(nzp), 32'h1);

        // ADD R4,R1,#-4 with R1=4
        wr(3'd1, 16'h0004);
        issue(16'h187C);
        tick();
        check("imm_exec_b", 32'(alu_b), 32'hFFFC);
        tick(); tick();
        check_reg("imm_r4", 3'd4, 16'h0000);
        check("imm_nzp", 32'(nzp), 32'h2);

        // AND R5,R1,R2 then NOT R6,R5
        wr(3'd1, 16'h00F0); wr(3'd2, 16'h0FF0);
        issue(16'h5A42);
        tick();
        check("and_exec_op", 32'(alu_opcode), 32'h5);
        tick(); tick();
        check_reg("and_r5", 3'd5, 16'h00F0);
        check("and_nzp", 32'(nzp), 32'h1);
        issue(16'h9D7F);
        tick();
        check("not_exec_op", 32'(alu_opcode), 32'h9);
        check("not_exec_a", 32'(alu_a), 32'h00F0);
        check("not_exec_b", 32'(alu_b), 32'h0000);
        tick(); tick();
        check_reg("not_r6", 3'd6, 16'hFF0F);
        check("not_nzp", 32'(nzp), 32'h4);

        // Unsupported opcode (BR) is dropped
        issue(16'h0000);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_ready", 32'(inst_ready), 32'd1);
        check("ill_done", 32'(done), 32'd0);
        tick();
        check("ill_clear", 32'(illegal), 32'd0);
        check("ill_nzp", 32'(nzp), 32'h4);
        check("ill_alu_hold", 32'(alu_opcode), 32'h9);
        check_reg("ill_r0", 3'd0, 16'h0000);
        check_reg("ill_r6", 3'd6, 16'hFF0F);

        // Back-to-back ADD R0,R0,#1 with inst_valid held high
        inst = 16'h1021;
        inst_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            check("b2b_ready_idle", 32'(inst_ready), 32'd1);
            tick();
            check("b2b_ready_c1", 32'(inst_ready), 32'd0);
            tick();
            check("b2b_ready_c2", 32'(inst_ready), 32'd0);
            tick();
            check("b2b_ready_c3", 32'(inst_ready), 32'd0);
            check("b2b_done_c3", 32'(done), 32'd1);
            if (n == 3) inst_valid = 1'b0;
            tick();
        end
        check_reg("b2b_r0", 3'd0, 16'd4);
        check("b2b_nzp", 32'(nzp), 32'h1);

        // External write during READ is not seen by that read: ADD R7,R1,R2
        issue(16'h1E42);
        wr(3'd1, 16'h1111);
        check("rd_old_a", 32'(alu_a), 32'h00F0);
        tick(); tick();
        check_reg("rd_r7", 3'd7, 16'h10E0);
        check_reg("rd_r1", 3'd1, 16'h1111);

        // WB beats a same-address external write: ADD R3,R1,R2 = 0x1111+0x0FF0
        issue(16'h1642);
        tick(); tick();
        check("col_wb_done", 32'(done), 32'd1);
        wr(3'd3, 16'hBEEF);
        check_reg("col_r3", 3'd3, 16'h2101);
        check("col_nzp", 32'(nzp), 32'h1);

        // Reset during EXEC aborts everything
        issue(16'h1642);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(inst_ready), 32'd1);
        check("abort_nzp", 32'(nzp), 32'h2);
        tick();
        check("abort_done_late", 32'(done), 32'd0);
        for (int r = 0; r < 8; r++) check_reg("abort_reg", 3'(r), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
